// File: rtl/usb_pkg.sv
// usb_pkg
// Shared definitions for the USB proxy and its transaction scheduler.
//   - pid_e         : PID byte values exactly as the proxy's capture shift
//                     register presents them (NRZI line levels, first bit
//                     on the wire in bit 0, line idle at 1 before the PID)
//   - sched_state_e : scheduler state encoding, also exported on sched_state
//   - FS/LS turnaround defaults in clk cycles (24 bit times)
package usb_pkg;

    localparam int unsigned FS_TIMEOUT_DEFAULT = 96;
    localparam int unsigned LS_TIMEOUT_DEFAULT = 768;
    localparam int unsigned TIMER_W            = 10;

    // Captured line-level form of each PID. The captured form is not the
    // {~pid, pid} byte seen after NRZI decoding.
    typedef enum logic [7:0] {
        PID_OUT   = 8'hF5,
        PID_IN    = 8'h8D,
        PID_SOF   = 8'hC9,
        PID_SETUP = 8'hB1,
        PID_DATA0 = 8'hEB,
        PID_DATA1 = 8'h93,
        PID_DATA2 = 8'hD7,
        PID_MDATA = 8'hAF,
        PID_ACK   = 8'hE4,
        PID_NAK   = 8'h9C,
        PID_STALL = 8'hA0,
        PID_NYET  = 8'hD8,
        PID_PING  = 8'hC6
    } pid_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_H_DATA = 3'd1,
        ST_D_HS   = 3'd2,
        ST_D_DATA = 3'd3,
        ST_H_HS   = 3'd4
    } sched_state_e;

    // The device side owns the bus only while it is expected to answer.
    function automatic logic host_listens(input sched_state_e s);
        return !((s == ST_D_HS) || (s == ST_D_DATA));
    endfunction

    function automatic logic is_legal_state(input sched_state_e s);
        return (s == ST_IDLE) || (s == ST_H_DATA) || (s == ST_D_HS) ||
               (s == ST_D_DATA) || (s == ST_H_HS);
    endfunction

endpackage

// File: rtl/usb_turnaround_timer.sv
// usb_turnaround_timer
// Counts clk cycles spent waiting for the next packet of a transaction.
// Ports:
//   clk, rst (async, active-low)
//   clear   : restart the wait; also samples is_fs to choose the limit
//   enable  : count this cycle (scheduler is in a non-IDLE state)
//   is_fs   : 1 = full-speed limit, 0 = low-speed limit
//   expired : the count reaches the limit on this clk edge
module usb_turnaround_timer
    import usb_pkg::*;
#(
    parameter int unsigned FS_TIMEOUT = FS_TIMEOUT_DEFAULT,
    parameter int unsigned LS_TIMEOUT = LS_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic is_fs,
    output logic expired
);

    localparam logic [TIMER_W-1:0] FS_LAST = TIMER_W'(FS_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] LS_LAST = TIMER_W'(LS_TIMEOUT - 1);

    logic [TIMER_W-1:0] cnt_q, cnt_d;
    logic               fs_q, fs_d;

    // The speed is frozen at entry so a mid-wait change of is_fs cannot
    // stretch or shorten the running wait. Expiry is flagged on the cycle
    // whose increment would land on the limit, so the N-th cycle of a wait
    // is the last one.
    always_comb begin
        cnt_d   = cnt_q;
        fs_d    = fs_q;
        expired = enable && (cnt_q == (fs_q ? FS_LAST : LS_LAST));
        if (clear) begin
            cnt_d = '0;
            fs_d  = is_fs;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            fs_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            fs_q  <= fs_d;
        end
    end

endmodule

// File: rtl/usb_txn_scheduler.sv
// usb_txn_scheduler
// Tracks the token / data / handshake phases of a USB transaction from the
// PIDs the proxy captures, and steers bus direction toward whichever side
// is expected to talk next.
// Ports:
//   clk, rst (async, active-low)
//   proxy_en    : 0 = bypass, host keeps the bus
//   is_fs       : 1 = full speed, 0 = low speed
//   pkt_valid   : one-cycle strobe at packet EOP, qualifies pkt_pid
//   pkt_pid     : captured PID byte
//   host_dir    : host side drives the bus
//   device_dir  : device side drives the bus
//   sched_state : current state encoding
//   xfer_done   : pulse, transaction completed
//   timeout_err : pulse, turnaround wait expired
//   pid_err     : pulse, PID not expected in the current state
//   txn_cnt     : completed transaction count, wraps
module usb_txn_scheduler
    import usb_pkg::*;
#(
    parameter int unsigned FS_TIMEOUT = FS_TIMEOUT_DEFAULT,
    parameter int unsigned LS_TIMEOUT = LS_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        proxy_en,
    input  logic        is_fs,
    input  logic        pkt_valid,
    input  logic [7:0]  pkt_pid,
    output logic        host_dir,
    output logic        device_dir,
    output logic [2:0]  sched_state,
    output logic        xfer_done,
    output logic        timeout_err,
    output logic        pid_err,
    output logic [15:0] txn_cnt
);

    sched_state_e state_q, state_d;
    logic         host_dir_q, host_dir_d;
    logic         device_dir_q, device_dir_d;
    logic         xfer_done_q, xfer_done_d;
    logic         timeout_err_q, timeout_err_d;
    logic         pid_err_q, pid_err_d;
    logic [15:0]  txn_cnt_q, txn_cnt_d;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    usb_turnaround_timer #(
        .FS_TIMEOUT (FS_TIMEOUT),
        .LS_TIMEOUT (LS_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .is_fs   (is_fs),
        .expired (timer_expired)
    );

    // Priority: bypass, then recovery from an illegal encoding, then a
    // received packet, then turnaround expiry. A packet arriving on the
    // expiry cycle therefore completes normally instead of timing out.
    always_comb begin
        state_d       = state_q;
        xfer_done_d   = 1'b0;
        timeout_err_d = 1'b0;
        pid_err_d     = 1'b0;

        if (!proxy_en) begin
            state_d = ST_IDLE;
        end else if (!is_legal_state(state_q)) begin
            state_d = ST_IDLE;
        end else if (pkt_valid) begin
            state_d = ST_IDLE;
            case (state_q)
                ST_IDLE: begin
                    if (pkt_pid == PID_OUT || pkt_pid == PID_SETUP) begin
                        state_d = ST_H_DATA;
                    end else if (pkt_pid == PID_IN) begin
                        state_d = ST_D_DATA;
                    end else if (pkt_pid == PID_PING) begin
                        state_d = ST_D_HS;
                    end else if (pkt_pid != PID_SOF) begin
                        pid_err_d = 1'b1;
                    end
                end
                ST_H_DATA: begin
                    if (pkt_pid == PID_DATA0 || pkt_pid == PID_DATA1) begin
                        state_d = ST_D_HS;
                    end else begin
                        pid_err_d = 1'b1;
                    end
                end
                ST_D_HS: begin
                    if (pkt_pid == PID_ACK || pkt_pid == PID_NAK ||
                        pkt_pid == PID_STALL || pkt_pid == PID_NYET) begin
                        xfer_done_d = 1'b1;
                    end else begin
                        pid_err_d = 1'b1;
                    end
                end
                ST_D_DATA: begin
                    if (pkt_pid == PID_DATA0 || pkt_pid == PID_DATA1) begin
                        state_d = ST_H_HS;
                    end else if (pkt_pid == PID_NAK || pkt_pid == PID_STALL) begin
                        xfer_done_d = 1'b1;
                    end else begin
                        pid_err_d = 1'b1;
                    end
                end
                ST_H_HS: begin
                    if (pkt_pid == PID_ACK) begin
                        xfer_done_d = 1'b1;
                    end else begin
                        pid_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (timer_expired) begin
            state_d       = ST_IDLE;
            timeout_err_d = 1'b1;
        end

        host_dir_d   = host_listens(state_d);
        device_dir_d = !host_listens(state_d);
        txn_cnt_d    = txn_cnt_q + 16'(xfer_done_d);
    end

    // Every state change restarts the wait for the next packet; bypass
    // keeps the timer parked at zero.
    always_comb begin
        timer_clear  = !proxy_en || (state_d != state_q);
        timer_enable = proxy_en && (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            host_dir_q    <= 1'b1;
            device_dir_q  <= 1'b0;
            xfer_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            pid_err_q     <= 1'b0;
            txn_cnt_q     <= 16'd0;
        end else begin
            state_q       <= state_d;
            host_dir_q    <= host_dir_d;
            device_dir_q  <= device_dir_d;
            xfer_done_q   <= xfer_done_d;
            timeout_err_q <= timeout_err_d;
            pid_err_q     <= pid_err_d;
            txn_cnt_q     <= txn_cnt_d;
        end
    end

    assign sched_state = state_q;
    assign host_dir    = host_dir_q;
    assign device_dir  = device_dir_q;
    assign xfer_done   = xfer_done_q;
    assign timeout_err = timeout_err_q;
    assign pid_err     = pid_err_q;
    assign txn_cnt     = txn_cnt_q;

endmodule

// File: tb/tb_usb_txn_scheduler.sv
// tb_usb_txn_scheduler
// Scoreboard bench for usb_txn_scheduler: the stimulus process runs a
// behavioural model at every clk edge and queues the expected registered
// outputs; an independent monitor pops and compares on the falling edge.
module tb_usb_txn_scheduler;

    localparam int FS_LIMIT = 96;
    localparam int LS_LIMIT = 768;

    // Model event codes
    localparam int EV_NONE = 0;
    localparam int EV_DONE = 1;
    localparam int EV_PERR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        proxy_en;
    logic        is_fs;
    logic        pkt_valid;
    logic [7:0]  pkt_pid;
    logic        host_dir;
    logic        device_dir;
    logic [2:0]  sched_state;
    logic        xfer_done;
    logic        timeout_err;
    logic        pid_err;
    logic [15:0] txn_cnt;

    typedef struct packed {
        logic [2:0]  st;
        logic        hd;
        logic        dd;
        logic        xd;
        logic        te;
        logic        pe;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_exp;
    exp_t mon_act;
    int   errors = 0;
    int   checks = 0;

    // PID values in captured line-level form
    logic [7:0] P_OUT, P_IN, P_SOF, P_SETUP, P_DATA0, P_DATA1, P_DATA2, P_MDATA;
    logic [7:0] P_ACK, P_NAK, P_STALL, P_NYET, P_PING;
    logic [7:0] pid_pool[13];

    // Transition rules keyed by state*256 + pid
    int rule_next[int];
    int rule_evt[int];

    // Model state
    int          m_state;
    int          m_wait;
    int          m_limit;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    usb_txn_scheduler #(
        .FS_TIMEOUT (FS_LIMIT),
        .LS_TIMEOUT (LS_LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .proxy_en    (proxy_en),
        .is_fs       (is_fs),
        .pkt_valid   (pkt_valid),
        .pkt_pid     (pkt_pid),
        .host_dir    (host_dir),
        .device_dir  (device_dir),
        .sched_state (sched_state),
        .xfer_done   (xfer_done),
        .timeout_err (timeout_err),
        .pid_err     (pid_err),
        .txn_cnt     (txn_cnt)
    );

    // Line levels the capture register sees for a PID: the {~code, code}
    // byte sent LSB first, NRZI coded from an idle level of 1.
    function automatic logic [7:0] wire_pid(input logic [3:0] code);
        logic [7:0] raw;
        logic [7:0] cap;
        logic       lvl;
        raw = {~code, code};
        lvl = 1'b1;
        cap = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (!raw[i]) lvl = ~lvl;
            cap[i] = lvl;
        end
        return cap;
    endfunction

    task automatic add_rule(input int s, input logic [7:0] pid, input int nxt, input int evt);
        rule_next[s * 256 + int'(pid)] = nxt;
        rule_evt[s * 256 + int'(pid)]  = evt;
    endtask

    // One clk edge of the reference: what the registered outputs must be
    // after this edge, given the inputs present at it.
    task automatic model_step();
        exp_t e;
        int   key;
        int   nxt;
        int   evt;
        e = '0;
        if (!proxy_en) begin
            m_state = 0;
            m_wait  = 0;
        end else if (pkt_valid) begin
            key = m_state * 256 + int'(pkt_pid);
            nxt = rule_next.exists(key) ? rule_next[key] : 0;
            evt = rule_evt.exists(key) ? rule_evt[key] : EV_PERR;
            if (nxt != 0 && nxt != m_state) begin
                m_wait  = 0;
                m_limit = is_fs ? FS_LIMIT : LS_LIMIT;
            end
            m_state = nxt;
            if (evt == EV_DONE) begin
                e.xd  = 1'b1;
                m_cnt = m_cnt + 16'd1;
            end
            if (evt == EV_PERR) e.pe = 1'b1;
        end else if (m_state != 0) begin
            m_wait++;
            if (m_wait == m_limit) begin
                e.te    = 1'b1;
                m_state = 0;
            end
        end
        e.st  = 3'(m_state);
        e.hd  = !(m_state == 2 || m_state == 3);
        e.dd  = (m_state == 2 || m_state == 3);
        e.cnt = m_cnt;
        sb_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic pv, input logic [7:0] pid);
        pkt_valid = pv;
        pkt_pid   = pid;
        @(posedge clk);
        model_step();
        #1;
        pkt_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom));
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] pick_pid();
        if ($urandom_range(0, 9) == 0) return 8'($urandom);
        return pid_pool[$urandom_range(0, 12)];
    endfunction

    task automatic random_txn();
        case ($urandom_range(0, 4))
            0: begin applyStimulus(1'b1, P_IN);    applyStimulus(1'b1, P_DATA1); applyStimulus(1'b1, P_ACK); end
            1: begin applyStimulus(1'b1, P_IN);    applyStimulus(1'b1, P_NAK); end
            2: begin applyStimulus(1'b1, P_OUT);   applyStimulus(1'b1, P_DATA0); applyStimulus(1'b1, P_ACK); end
            3: begin applyStimulus(1'b1, P_PING);  applyStimulus(1'b1, P_NYET); end
            default: begin applyStimulus(1'b1, P_SETUP); applyStimulus(1'b1, P_DATA0); applyStimulus(1'b1, P_STALL); end
        endcase
    endtask

    // Monitor: every registered output is compared against the queued
    // expectation on the falling edge following the edge that produced it.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                mon_exp = sb_q.pop_front();
                mon_act = {sched_state, host_dir, device_dir, xfer_done, timeout_err, pid_err, txn_cnt};
                checks++;
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("[TB] FAIL cycle_check t=%0t: got st=%0d hd=%0b dd=%0b xd=%0b te=%0b pe=%0b cnt=%0d, required st=%0d hd=%0b dd=%0b xd=%0b te=%0b pe=%0b cnt=%0d",
                             $time, mon_act.st, mon_act.hd, mon_act.dd, mon_act.xd, mon_act.te, mon_act.pe, mon_act.cnt,
                             mon_exp.st, mon_exp.hd, mon_exp.dd, mon_exp.xd, mon_exp.te, mon_exp.pe, mon_exp.cnt);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        P_OUT   = wire_pid(4'b0001);
        P_IN    = wire_pid(4'b1001);
        P_SOF   = wire_pid(4'b0101);
        P_SETUP = wire_pid(4'b1101);
        P_DATA0 = wire_pid(4'b0011);
        P_DATA1 = wire_pid(4'b1011);
        P_DATA2 = wire_pid(4'b0111);
        P_MDATA = wire_pid(4'b1111);
        P_ACK   = wire_pid(4'b0010);
        P_NAK   = wire_pid(4'b1010);
        P_STALL = wire_pid(4'b1110);
        P_NYET  = wire_pid(4'b0110);
        P_PING  = wire_pid(4'b0100);
        pid_pool = '{P_OUT, P_IN, P_SOF, P_SETUP, P_DATA0, P_DATA1, P_DATA2,
                     P_MDATA, P_ACK, P_NAK, P_STALL, P_NYET, P_PING};

        // States: 0 IDLE, 1 H_DATA, 2 D_HS, 3 D_DATA, 4 H_HS
        add_rule(0, P_OUT,   1, EV_NONE);
        add_rule(0, P_SETUP, 1, EV_NONE);
        add_rule(0, P_IN,    3, EV_NONE);
        add_rule(0, P_PING,  2, EV_NONE);
        add_rule(0, P_SOF,   0, EV_NONE);
        add_rule(1, P_DATA0, 2, EV_NONE);
        add_rule(1, P_DATA1, 2, EV_NONE);
        add_rule(2, P_ACK,   0, EV_DONE);
        add_rule(2, P_NAK,   0, EV_DONE);
        add_rule(2, P_STALL, 0, EV_DONE);
        add_rule(2, P_NYET,  0, EV_DONE);
        add_rule(3, P_DATA0, 4, EV_NONE);
        add_rule(3, P_DATA1, 4, EV_NONE);
        add_rule(3, P_NAK,   0, EV_DONE);
        add_rule(3, P_STALL, 0, EV_DONE);
        add_rule(4, P_ACK,   0, EV_DONE);

        m_state = 0;
        m_wait  = 0;
        m_limit = FS_LIMIT;
        m_cnt   = 16'd0;

        rst       = 1'b0;
        proxy_en  = 1'b1;
        is_fs     = 1'b1;
        pkt_valid = 1'b1;
        pkt_pid   = P_IN;

        // Held in reset across clk edges with a packet presented.
        #22;
        checkOutput("rst_host_dir",    32'(host_dir),    32'd1);
        checkOutput("rst_device_dir",  32'(device_dir),  32'd0);
        checkOutput("rst_state",       32'(sched_state), 32'd0);
        checkOutput("rst_xfer_done",   32'(xfer_done),   32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_pid_err",     32'(pid_err),     32'd0);
        checkOutput("rst_txn_cnt",     32'(txn_cnt),     32'd0);
        pkt_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // IN, DATA1, ACK at full speed
        applyStimulus(1'b1, P_IN);
        applyStimulus(1'b1, P_DATA1);
        applyStimulus(1'b1, P_ACK);
        idle_cycles(2);

        // SETUP, DATA0, then silence: D_HS times out on its 96th cycle
        applyStimulus(1'b1, P_SETUP);
        applyStimulus(1'b1, P_DATA0);
        idle_cycles(100);

        // Handshake where data was expected
        applyStimulus(1'b1, P_IN);
        applyStimulus(1'b1, P_ACK);
        idle_cycles(1);

        // Low speed: NAK on the 768th cycle wins over expiry
        is_fs = 1'b0;
        applyStimulus(1'b1, P_IN);
        idle_cycles(LS_LIMIT - 1);
        applyStimulus(1'b1, P_NAK);
        idle_cycles(2);

        // Low speed: silence expires the wait
        applyStimulus(1'b1, P_IN);
        idle_cycles(LS_LIMIT + 2);

        // Speed flips after entry: the full-speed limit still applies
        is_fs = 1'b1;
        applyStimulus(1'b1, P_PING);
        is_fs = 1'b0;
        idle_cycles(FS_LIMIT + 4);
        is_fs = 1'b1;

        // SOF in IDLE is ignored; stray handshake in IDLE is a PID error
        applyStimulus(1'b1, P_SOF);
        applyStimulus(1'b1, P_ACK);

        // Bypass during H_DATA: IDLE next clk, packets ignored, no pulses
        applyStimulus(1'b1, P_OUT);
        proxy_en = 1'b0;
        applyStimulus(1'b1, P_DATA0);
        applyStimulus(1'b1, P_IN);
        idle_cycles(2);
        proxy_en = 1'b1;
        idle_cycles(1);

        // Asynchronous reset while in D_DATA
        applyStimulus(1'b1, P_IN);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_host_dir",   32'(host_dir),    32'd1);
        checkOutput("async_rst_device_dir", 32'(device_dir),  32'd0);
        checkOutput("async_rst_state",      32'(sched_state), 32'd0);
        checkOutput("async_rst_txn_cnt",    32'(txn_cnt),     32'd0);
        m_state = 0;
        m_wait  = 0;
        m_cnt   = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        idle_cycles(1);

        // Preset the transaction counter near its wrap point rather than
        // running 65535 transactions.
        @(negedge clk);
        #1;
        force dut.txn_cnt_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        applyStimulus(1'b0, 8'h00);
        release dut.txn_cnt_q;
        applyStimulus(1'b1, P_OUT);
        applyStimulus(1'b1, P_DATA0);
        applyStimulus(1'b1, P_ACK);
        applyStimulus(1'b1, P_OUT);
        applyStimulus(1'b1, P_DATA0);
        applyStimulus(1'b1, P_ACK);
        @(negedge clk);
        #1;
        checkOutput("wrap_txn_cnt", 32'(txn_cnt), 32'd0);

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) is_fs = 1'($urandom_range(0, 1));
            proxy_en = ($urandom_range(0, 39) != 0);
            case ($urandom_range(0, 29))
                0:       idle_cycles($urandom_range(20, 120));
                1, 2, 3: random_txn();
                default: begin
                    if ($urandom_range(0, 2) == 0) applyStimulus(1'b1, pick_pid());
                    else applyStimulus(1'b0, 8'($urandom));
                end
            endcase
        end

        proxy_en = 1'b1;
        idle_cycles(3);
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_txn_scheduler.md
USB_TXN_SCHEDULER -- requirements
Module: usb_txn_scheduler

Interface
REQ-001 SHALL have parameter FS_TIMEOUT, default 96, meaning the full-speed turnaround limit in clk cycles (24 bit times at 4 clk/bit).
REQ-002 SHALL have parameter LS_TIMEOUT, default 768, meaning the low-speed turnaround limit in clk cycles (24 bit times at 32 clk/bit).
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port proxy_en, input, 1 bit: scheduling enable; 0 = bypass (host drives).
REQ-006 SHALL have port is_fs, input, 1 bit: 1 = full speed, 0 = low speed.
REQ-007 SHALL have port pkt_valid, input, 1 bit: one-cycle strobe at packet EOP.
REQ-008 SHALL have port pkt_pid, input, 8 bits: the PID of the completed packet, qualified by pkt_valid.
REQ-009 SHALL have port host_dir, output, 1 bit: 1 = host side listened (host drives the bus).
REQ-010 SHALL have port device_dir, output, 1 bit: 1 = device side listened (device drives the bus).
REQ-011 SHALL have port sched_state, output, 3 bits: current state encoding.
REQ-012 SHALL have port xfer_done, output, 1 bit: one-cycle pulse on transaction completion.
REQ-013 SHALL have port timeout_err, output, 1 bit: one-cycle pulse on expiry of a turnaround wait.
REQ-014 SHALL have port pid_err, output, 1 bit: one-cycle pulse on a PID that is unexpected in the current state.
REQ-015 SHALL have port txn_cnt, output, 16 bits: count of completed transactions.

Function
REQ-016 SHALL implement the states IDLE=0, H_DATA=1, D_HS=2, D_DATA=3 and H_HS=4; encodings 5-7 SHALL go to IDLE on the next clk.
REQ-017 SHALL drive the direction outputs per state: host_dir=1, device_dir=0 in IDLE, H_DATA and H_HS; host_dir=0, device_dir=1 in D_HS and D_DATA.
REQ-018 SHALL register all outputs, so that direction changes appear on the clk after the pkt_valid that causes the transition.
REQ-019 IDLE: SHALL go to H_DATA on OUT or SETUP, to D_DATA on IN, and to D_HS on Ping.
REQ-020 IDLE: SHALL ignore SOF and stay in IDLE.
REQ-021 IDLE: SHALL pulse pid_err on any other PID and stay in IDLE.
REQ-022 H_DATA: SHALL go to D_HS on DATA0 or DATA1; any other PID SHALL pulse pid_err and go to IDLE.
REQ-023 D_HS: SHALL pulse xfer_done and go to IDLE on ACK, NAK, STALL or NYET; any other PID SHALL pulse pid_err and go to IDLE.
REQ-024 D_DATA: SHALL go to H_HS on DATA0 or DATA1, and SHALL pulse xfer_done and go to IDLE on NAK or STALL; any other PID SHALL pulse pid_err and go to IDLE.
REQ-025 H_HS: SHALL pulse xfer_done and go to IDLE on ACK; any other PID SHALL pulse pid_err and go to IDLE.
REQ-026 SHALL use the PID encodings of the shared package, bit-exact as the proxy captures them (e.g. IN=8'b10001101, ACK=8'b11100100).
REQ-027 Timeout counter: 10 bits, cleared on entry to any non-IDLE state, incremented every clk while in a non-IDLE state.
REQ-028 Timeout limit: SHALL be selected by is_fs as latched at state entry; a later change of is_fs SHALL not affect the running wait.
REQ-029 On the counter reaching the limit, the block SHALL pulse timeout_err, go to IDLE, and SHALL NOT pulse xfer_done.
REQ-030 When pkt_valid and timeout expiry occur in the same cycle, pkt_valid SHALL win and timeout_err SHALL NOT pulse.
REQ-031 txn_cnt SHALL increment by 1 on each xfer_done and wrap from 16'hFFFF to 0.
REQ-032 When proxy_en=0, the block SHALL force IDLE, host_dir=1 and device_dir=0, clear the timeout counter, and ignore pkt_valid; txn_cnt SHALL hold.
REQ-033 When proxy_en falls mid-transaction, the block SHALL be in IDLE on the next clk with no error pulse.
REQ-034 At most one of xfer_done, timeout_err and pid_err SHALL pulse in any cycle.

Reset
REQ-035 While rst=0, the block SHALL be held in IDLE, asynchronously.
REQ-036 While rst=0: host_dir=1, device_dir=0, sched_state=0, xfer_done=0, timeout_err=0, pid_err=0, txn_cnt=0, timeout counter=0.
REQ-037 On rst release, the first transition SHALL be evaluated on the first rising clk edge after release.

Structure
REQ-038 The PID enum, the state enum and the FS_TIMEOUT/LS_TIMEOUT defaults SHALL live in shared package usb_pkg, which the proxy also imports.
REQ-039 The timeout counter SHALL be sub-module usb_turnaround_timer (inputs clear, enable, is_fs; output expired).
REQ-040 The FSM and the counters SHALL live in usb_txn_scheduler.

Verification
REQ-041 IN, DATA1, ACK at FS -> device_dir=1 after IN; host_dir=1 after DATA1; xfer_done once; txn_cnt 0->1.
REQ-042 SETUP, DATA0, then no packet for 96 clk at FS -> timeout_err pulse on cycle 96 of D_HS; state=0; txn_cnt unchanged.
REQ-043 IN, then ACK -> pid_err pulse; state=0; host_dir=1, device_dir=0.
REQ-044 LS IN, with NAK arriving at clk 768 -> xfer_done and no timeout_err (REQ-030 boundary).
REQ-045 txn_cnt preset via 65535 OUT/DATA0/ACK transactions, then one more -> txn_cnt=0.
REQ-046 rst=0 asserted in D_DATA -> host_dir=1 immediately, without clk; proxy_en=0 during H_DATA -> IDLE on next clk, no error pulses.
